// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and status-register bit positions
// for the single-bit SPI flash program/erase engine.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN    = 8'h06;
  localparam logic [7:0] OP_PP      = 8'h02;
  localparam logic [7:0] OP_RDSR    = 8'h05;
  localparam logic [7:0] OP_SE      = 8'h20;
  localparam logic [7:0] OP_QREAD   = 8'hEB;
  localparam logic [7:0] CMRST_BYTE = 8'hFF;

  localparam int WIP_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMRST,
    ST_GAP,
    ST_WREN,
    ST_PROG,
    ST_SERASE,
    ST_POLL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_shift_out.sv
// Loadable 64-bit MSB-first shift register with a down-counting bit counter;
// updates on the falling edge so the flash sees stable data on the rising edge.
module spi_shift_out (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [63:0] data_i,
  input  logic [6:0]  len_i,
  output logic        bit_o,
  output logic        last_o
);

  logic [63:0] sreg_q;
  logic [6:0]  bcnt_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      bcnt_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      bcnt_q <= len_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[62:0], 1'b0};
      bcnt_q <= bcnt_q - 7'd1;
    end
  end

  assign bit_o  = sreg_q[63];
  assign last_o = (bcnt_q == 7'd1);

endmodule

// File: rtl/spi_flash_writer.sv
// Programs one 32-bit word (or, with SPI_FLASH_WRITER_ERASE_EN, erases a 4 KB
// sector) over single-bit SPI: mode reset, WREN, PP/SE, then RDSR polling.
module spi_flash_writer
  import spi_flash_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int POLL_MAX   = 65535,
  parameter int POLL_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] address,
  input  logic [31:0] data,
  input  logic        start,
`ifdef SPI_FLASH_WRITER_ERASE_EN
  input  logic        erase,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cs,
  output logic        d,
  input  logic        q,
  output logic        wp,
  output logic        hold,
  output state_e      dbg_state
);

  localparam logic [6:0]        GAP_LEN  = 7'(GAP_CYCLES);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);

  state_e             state_q, state_d, ret_q, ret_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [23:0]        addr_q, addr_d;
  logic [31:0]        word_q, word_d;
  logic               erase_q, erase_d, erase_in;
  logic [POLL_W-1:0]  poll_q, poll_d, poll_inc;
  logic               stat_ph_q, stat_ph_d;
  logic [6:0]         stat_q, stat_d;
  logic [7:0]         status;
  logic               q_r;
  logic               ld, sh, last, sbit;
  logic [63:0]        ld_data;
  logic [6:0]         ld_len;
  logic               unused_bits;

`ifdef SPI_FLASH_WRITER_ERASE_EN
  assign erase_in = erase;
`else
  assign erase_in = 1'b0;
`endif

  // The byte address is address<<2; the two top word-address bits fall off.
  assign unused_bits = ^{address[23:22], OP_QREAD};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_r <= 1'b0;
    else        q_r <= q;
  end

  spi_shift_out u_shift (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (ld),
    .shift_i (sh),
    .data_i  (ld_data),
    .len_i   (ld_len),
    .bit_o   (sbit),
    .last_o  (last)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      word_q    <= '0;
      erase_q   <= 1'b0;
      poll_q    <= '0;
      stat_ph_q <= 1'b0;
      stat_q    <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      erase_q   <= erase_d;
      poll_q    <= poll_d;
      stat_ph_q <= stat_ph_d;
      stat_q    <= stat_d;
    end
  end

  assign poll_inc = poll_q + POLL_W'(1);
  assign status   = {stat_q, q_r};

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    addr_d    = addr_q;
    word_d    = word_q;
    erase_d   = erase_q;
    poll_d    = poll_q;
    stat_ph_d = stat_ph_q;
    stat_d    = stat_q;
    ld        = 1'b0;
    sh        = 1'b0;
    ld_data   = '0;
    ld_len    = 7'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          addr_d  = {address[21:0], 2'b00};
          word_d  = data;
          erase_d = erase_in;
          state_d = ST_CMRST;
          ld      = 1'b1;
          ld_data = {CMRST_BYTE, 56'h0};
          ld_len  = 7'd8;
        end
      end
      ST_CMRST, ST_WREN, ST_PROG, ST_SERASE: begin
        if (!last) begin
          sh = 1'b1;
        end else begin
          // The gap reuses the shifter: zeros keep d low while it counts.
          state_d = ST_GAP;
          ld      = 1'b1;
          ld_len  = GAP_LEN;
          case (state_q)
            ST_CMRST: ret_d = ST_WREN;
            ST_WREN:  ret_d = erase_q ? ST_SERASE : ST_PROG;
            default:  ret_d = ST_POLL;
          endcase
        end
      end
      ST_GAP: begin
        if (!last) begin
          sh = 1'b1;
        end else begin
          state_d = ret_q;
          ld      = 1'b1;
          case (ret_q)
            ST_WREN: begin
              ld_data = {OP_WREN, 56'h0};
              ld_len  = 7'd8;
            end
            ST_PROG: begin
              ld_data = {OP_PP, addr_q, word_q};
              ld_len  = 7'd64;
            end
            ST_SERASE: begin
              ld_data = {OP_SE, addr_q[23:12], 12'h000, 32'h0};
              ld_len  = 7'd32;
            end
            default: begin
              ld_data   = {OP_RDSR, 56'h0};
              ld_len    = 7'd8;
              stat_ph_d = 1'b0;
              poll_d    = '0;
            end
          endcase
        end
      end
      ST_POLL: begin
        if (!last) begin
          sh = 1'b1;
          if (stat_ph_q) stat_d = {stat_q[5:0], q_r};
        end else if (!stat_ph_q) begin
          stat_ph_d = 1'b1;
          ld        = 1'b1;
          ld_len    = 7'd8;
        end else if (!status[WIP_BIT]) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          ld      = 1'b1;
          ld_len  = 7'd1;
        end else if (poll_inc == POLL_LIM) begin
          poll_d  = poll_inc;
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          ld      = 1'b1;
          ld_len  = 7'd1;
        end else begin
          // Status bytes stream back-to-back; RDSR is not resent.
          poll_d = poll_inc;
          ld     = 1'b1;
          ld_len = 7'd8;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cs        = (state_q == ST_IDLE) || (state_q == ST_GAP) || (state_q == ST_DONE);
  assign d         = sbit;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wp        = 1'b1;
  assign hold      = 1'b1;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: a behavioural SPI flash (byte frames, WEL, memory)
// plus frame/done scoreboards fed by the stimulus tasks.
module tb_spi_flash_writer;
  import spi_flash_pkg::*;

  localparam int GAP  = 4;
  localparam int PMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] address = '0;
  logic [31:0] data = '0;
  logic        q = 1'b0;
  logic        busy, done, err, cs, d, wp, hold;
  state_e      dbg_state;
`ifdef SPI_FLASH_WRITER_ERASE_EN
  logic        erase = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_flash_writer #(.GAP_CYCLES(GAP), .POLL_MAX(PMAX), .POLL_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .start     (start),
`ifdef SPI_FLASH_WRITER_ERASE_EN
    .erase     (erase),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cs        (cs),
    .d         (d),
    .q         (q),
    .wp        (wp),
    .hold      (hold),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Frame: {byte count, first eight bytes left-justified}.
  logic [71:0] exp_frame_q[$];
  // Done: {err, erase, byte address, expected word}.
  logic [57:0] exp_done_q[$];

  logic [7:0] mem [int];
  logic [7:0] fb[$];
  logic [7:0] sh_b = '0;
  int         bitn = 0;
  logic       in_frame = 1'b0;
  logic       wel = 1'b0;
  logic       abort_frame = 1'b0;
  int         wip_n = 0;

  function automatic logic [7:0] mrd(input int a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic end_frame();
    logic [71:0] got;
    int a;
    int ad;
    if (abort_frame) begin
      abort_frame = 1'b0;
      return;
    end
    got = '0;
    got[71:64] = (bitn % 8 != 0) ? 8'hFF : 8'(fb.size());
    for (int i = 0; i < 8 && i < fb.size(); i++) got[63-8*i -: 8] = fb[i];
    if (exp_frame_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame: unexpected frame %0h", got);
    end else begin
      check("frame", got, exp_frame_q.pop_front());
    end
    check("wp_hold", {70'b0, wp, hold}, 72'h3);
    if (bitn % 8 == 0 && fb.size() > 0) begin
      case (fb[0])
        OP_WREN: wel = 1'b1;
        OP_PP: if (wel && fb.size() >= 4) begin
          a = int'({fb[1], fb[2], fb[3]});
          for (int i = 4; i < fb.size(); i++) begin
            ad = (a & 32'h00FFFF00) | ((a + i - 4) & 32'hFF);
            mem[ad] = mrd(ad) & fb[i];
          end
          wel = 1'b0;
        end
        OP_SE: if (wel && fb.size() == 4) begin
          a = int'({fb[1], fb[2], fb[3]}) & 32'h00FFF000;
          for (int i = 0; i < 4096; i++) mem[a+i] = 8'hFF;
          wel = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // Flash receive side: samples d on the rising edge while selected.
  always @(posedge clk) begin
    if (cs === 1'b0) begin
      in_frame = 1'b1;
      sh_b = {sh_b[6:0], d};
      bitn++;
      if (bitn % 8 == 0) fb.push_back(sh_b);
    end else if (in_frame) begin
      end_frame();
      in_frame = 1'b0;
      bitn = 0;
      fb.delete();
    end
  end

  // Flash status output: WIP=1 for the first wip_n status bytes of a read.
  always @(negedge clk) begin
    int k;
    q = 1'b0;
    if (in_frame && fb.size() > 0 && fb[0] == OP_RDSR && bitn >= 8) begin
      k = bitn - 8;
      q = ((k / 8) < wip_n) && ((k % 8) == 7);
    end
  end

  int gap_cnt = 0;
  always @(posedge clk) begin
    if (busy !== 1'b1) gap_cnt = 0;
    else if (cs) gap_cnt++;
    else if (gap_cnt != 0) begin
      check("gap_len", 72'(gap_cnt), 72'(GAP));
      gap_cnt = 0;
    end
  end

  logic        done_prev = 1'b0;
  logic [57:0] e;
  int          eba;
  logic [31:0] gw;
  logic        sec_ok;
  always @(posedge clk) begin
    if (done_prev) check("done_pulse_end", {70'b0, done, busy}, 72'h0);
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done: unexpected done pulse err=%0b", err);
      end else begin
        e = exp_done_q.pop_front();
        check("err", 72'(err), 72'(e[57]));
        check("done_cs_busy", {70'b0, cs, busy}, 72'h3);
        eba = int'(e[55:32]);
        if (!e[56]) begin
          gw = {mrd(eba), mrd(eba+1), mrd(eba+2), mrd(eba+3)};
          check("mem_word", 72'(gw), 72'(e[31:0]));
        end else begin
          sec_ok = 1'b1;
          for (int i = 0; i < 4096; i++)
            if (mrd((eba & 32'h00FFF000) + i) != 8'hFF) sec_ok = 1'b0;
          check("sector_erased", 72'(sec_ok), 72'h1);
        end
      end
    end
    done_prev = done;
  end

  task automatic push_exp(input logic [23:0] a, input logic [31:0] w, input logic er,
                          input int wn, input bit with_done);
    int ba;
    int np;
    logic [31:0] sa;
    logic [31:0] exp_w;
    ba = int'({a[21:0], 2'b00});
    sa = ba & 32'h00FFF000;
    np = (wn + 1 < PMAX) ? wn + 1 : PMAX;
    exp_frame_q.push_back({8'd1, 8'hFF, 56'h0});
    exp_frame_q.push_back({8'd1, OP_WREN, 56'h0});
    if (!with_done) return;
    if (er) exp_frame_q.push_back({8'd4, OP_SE, sa[23:0], 32'h0});
    else    exp_frame_q.push_back({8'd8, OP_PP, 8'(ba >> 16), 8'(ba >> 8), 8'(ba), w});
    exp_frame_q.push_back({8'(1 + np), OP_RDSR, 56'h0});
    exp_w = {mrd(ba) & w[31:24], mrd(ba+1) & w[23:16], mrd(ba+2) & w[15:8], mrd(ba+3) & w[7:0]};
    exp_done_q.push_back({(wn >= PMAX), er, 24'(ba), exp_w});
  endtask

  task automatic drive_start(input logic [23:0] a, input logic [31:0] w, input logic er);
    @(posedge clk);
    address = a;
    data = w;
`ifdef SPI_FLASH_WRITER_ERASE_EN
    erase = er;
`endif
    start = 1'b1;
  endtask

  task automatic drain_check();
    repeat (3) @(posedge clk);
    check("drain", {56'b0, busy, 7'(exp_frame_q.size()), 8'(exp_done_q.size())}, 72'h0);
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [31:0] w, input logic er,
                         input int wn, input bit hammer);
    bit fin;
    fin = 1'b0;
    wip_n = wn;
    push_exp(a, w, er, wn, 1'b1);
    drive_start(a, w, er);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      start = hammer ? busy : 1'b0;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: busy still %0b, expected 0", busy);
    end
    drain_check();
  endtask

  task automatic reset_mid_prog(input logic [23:0] a, input logic [31:0] w);
    bit hit;
    hit = 1'b0;
    wip_n = 0;
    push_exp(a, w, 1'b0, 0, 1'b0);
    drive_start(a, w, 1'b0);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      start = 1'b0;
      if (dbg_state == ST_PROG) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_prog", 72'(hit), 72'h1);
    repeat (19) @(posedge clk);
    #2;
    abort_frame = 1'b1;
    reset = 1'b0;
    #1;
    check("reset_mid_op", {69'b0, cs, busy, done}, 72'h4);
    repeat (3) @(posedge clk);
    reset = 1'b1;
    drain_check();
  endtask

  initial begin
    logic [23:0] ra;
    logic [31:0] rw;
    logic        rer;
    #3;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    check("reset_state", {67'b0, cs, d, busy, done, err}, 72'h10);
    reset = 1'b1;
    @(posedge clk);

    run_txn(24'h000010, 32'hDEADBEEF, 1'b0, 3, 1'b0);
    check("mem_0x40", 72'({mrd(32'h40), mrd(32'h41), mrd(32'h42), mrd(32'h43)}), 72'hDEADBEEF);

    run_txn(24'h000123, 32'h12345678, 1'b0, 1, 1'b1);
    run_txn(24'h000200, 32'hA5A5A5A5, 1'b0, 100, 1'b0);

    reset_mid_prog(24'h000300, 32'hCAFEF00D);
    run_txn(24'h000300, 32'hCAFEF00D, 1'b0, 2, 1'b0);

`ifdef SPI_FLASH_WRITER_ERASE_EN
    for (int i = 0; i < 4096; i++) mem[32'h3000 + i] = 8'h00;
    run_txn(24'h000C05, 32'h00000000, 1'b1, 2, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      ra = 24'($urandom);
      rw = $urandom;
`ifdef SPI_FLASH_WRITER_ERASE_EN
      rer = 1'($urandom_range(0, 1));
`else
      rer = 1'b0;
`endif
      run_txn(ra, rw, rer, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
